zero_check_arbiter: RTL and testbench
=====================================

ZERO_CHECK_ARBITER -- requirements
Module: zero_check_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, the operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, the number of requesters (fixed at 4 for this revision).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: when high, new grants are allowed.
REQ-006 The block SHALL have port req, input, NREQ bits: level request per requester.
REQ-007 The block SHALL have port data, input, NREQ x WIDTH bits: the operand of each requester.
REQ-008 The block SHALL have port ack, output, NREQ bits: one-cycle completion pulse, one-hot or zero.
REQ-009 The block SHALL have port zero, output, 1 bit: result for the acked requester; 1 iff its operand was all zeros.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in the result stage.
REQ-011 The block SHALL have port ops_count, output, 16 bits: completed operations, saturating.
REQ-012 The block SHALL have port zero_count, output, 16 bits: completed operations with zero=1, saturating.

Function
REQ-013 Stage 1 (grant), cycle t: candidates = req AND NOT inflight, where inflight = onehot(id_q) when valid_q, else 0.
REQ-014 If en=1 and candidates != 0, the winner SHALL be the first set candidate searching upward from ptr with wrap-around (3 -> 0).
REQ-015 On the edge ending cycle t, the block SHALL load: op_q <= data[winner]; id_q <= winner; valid_q <= 1; ptr <= (winner+1) mod NREQ.
REQ-016 With no winner (en=0 or candidates=0), the edge SHALL load valid_q <= 0 and hold ptr, op_q and id_q.
REQ-017 Stage 2 (result), cycle t+1: ack[id_q] = valid_q and all other ack bits 0; zero = NOR of all WIDTH bits of op_q; busy = valid_q.
REQ-018 Latency from grant edge to ack SHALL be exactly 1 cycle; from req rise to ack, at most 1+2*(NREQ-1) cycles when en=1 (starvation bound: 7 cycles for NREQ=4).
REQ-019 Handshake: a requester SHALL hold req and data stable until its ack cycle; req still high in the cycle after ack is a new request.
REQ-020 The inflight mask SHALL prevent regranting the requester in stage 2; a continuously requesting requester is served at most every other cycle while other requesters can fill the gaps, giving back-to-back throughput of 1 op/cycle.
REQ-021 When ack is not asserted, zero SHALL be 0.
REQ-022 On each cycle with valid_q=1, ops_count SHALL increment, and zero_count SHALL increment when zero=1; each counter SHALL hold at 16'hFFFF and never wrap.
REQ-023 When en falls, an operation already in stage 2 SHALL still complete and ack.
REQ-024 A requester dropping req before its grant SHALL simply not be granted; no ack SHALL occur for it.
REQ-025 Changes to req or data during a requester's stage 2 SHALL NOT affect the current zero output.

Reset
REQ-026 While reset=0, asynchronously: valid_q=0, id_q=0, op_q=0, ptr=0, ops_count=0, zero_count=0; hence ack=0, zero=0, busy=0.
REQ-027 Reset asserted mid-operation SHALL abort the in-flight operation with no ack; the first grant after release SHALL use ptr=0.

Verification
REQ-028 Single request: req=4'b0100, data[2]=0, en=1 -> ack=4'b0100 with zero=1 one cycle after grant; ops_count=1, zero_count=1.
REQ-029 Nonzero operand: req=4'b0001, data[0]=64'h8000_0000_0000_0000 -> ack=4'b0001 with zero=0; repeat for every single-bit position 0..63 -> zero=0 each time.
REQ-030 Round-robin: req=4'b1111 held continuously from reset -> ack order 0,1,2,3,0,... one per cycle; no requester is acked twice in a row.
REQ-031 Requester 1 alone holds req high for 6 cycles -> ack[1] pulses every other cycle; busy alternates 1,0.
REQ-032 Assert reset low while valid_q=1 -> ack=0, counters=0 immediately; release with req=4'b1010 -> first ack is requester 1.
REQ-033 Preload ops_count=16'hFFFE by running 65534 ops, then run 3 more -> ops_count=16'hFFFF and stays there; en=0 with req=4'b1111 -> no ack after the in-flight operation completes.

Source files
------------

// File: rtl/zero_check_arbiter_if.sv
// Request/result bundle for zero_check_arbiter.
//
// Handshake: req[i] is a level request. A requester keeps req[i] and
// data[i] stable from the moment it raises req[i] until the cycle in which
// ack[i] pulses. ack[i] is a single-cycle completion pulse, and zero is
// meaningful only in that cycle. If req[i] is still high in the cycle after
// ack[i], that is a new request. If req[i] is dropped before it is granted,
// the request is withdrawn and no ack follows. en gates new grants only; an
// operation that has already been granted always completes.
interface zero_check_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
);
    logic                       en;
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][WIDTH-1:0] data;
    logic [NREQ-1:0]            ack;
    logic                       zero;
    logic                       busy;

    // Requester side drives requests and operands.
    modport master (
        output en,
        output req,
        output data,
        input  ack,
        input  zero,
        input  busy
    );

    // Arbiter side consumes requests and produces results.
    modport slave (
        input  en,
        input  req,
        input  data,
        output ack,
        output zero,
        output busy
    );
endinterface

// File: rtl/zero_check_arbiter.sv
// Round-robin arbiter with a two-stage zero-detect pipeline.
//
// Stage 1 picks one requester per cycle and captures its operand. Stage 2
// reports whether that operand was all zeros and pulses the requester's ack.
// The requester that currently sits in stage 2 is masked out of stage 1. This
// keeps it from being granted again on a request it has not yet seen acked,
// while the other requesters can still use the slot, so throughput stays at
// one operation per cycle.
//
// NREQ is fixed at 4 in this revision. The rotating pointer wraps by natural
// overflow of its IDW-bit width, which is only correct for power-of-two NREQ.
module zero_check_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    zero_check_arbiter_if.slave  bus,
    output logic [15:0]          ops_count,
    output logic [15:0]          zero_count
);

    localparam int          IDW     = $clog2(NREQ);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Stage-2 (result) registers
    logic             valid_q, valid_d;
    logic [IDW-1:0]   id_q,    id_d;
    logic [WIDTH-1:0] op_q,    op_d;

    // Round-robin search start
    logic [IDW-1:0]   ptr_q,   ptr_d;

    // Saturating statistics counters
    logic [15:0]      ops_count_q,  ops_count_d;
    logic [15:0]      zero_count_q, zero_count_d;

    // Stage-1 arbitration signals
    logic [NREQ-1:0]  inflight;
    logic [NREQ-1:0]  candidates;
    logic             win_found;
    logic [IDW-1:0]   winner;
    logic             grant;

    // Stage-2 result signals
    logic             zero_now;
    logic [NREQ-1:0]  ack_w;

    // Mask out the requester whose operation is currently in stage 2.
    always_comb begin
        inflight = '0;
        if (valid_q) begin
            inflight[id_q] = 1'b1;
        end
        candidates = bus.req & ~inflight;
    end

    // Find the first candidate at or above ptr_q, wrapping from the top index to 0.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        winner    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_q + IDW'(i);
            if (!win_found && candidates[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    assign grant = bus.en & win_found;

    // Next state of the pipeline. The winner's operand is captured at the
    // grant edge, so later changes to req or data cannot disturb the result.
    always_comb begin
        valid_d = grant;
        id_d    = id_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        if (grant) begin
            id_d  = winner;
            op_d  = bus.data[winner];
            ptr_d = winner + IDW'(1);
        end
    end

    // Stage-2 outputs are derived from registers only.
    always_comb begin
        ack_w    = '0;
        zero_now = valid_q & ~(|op_q);
        if (valid_q) begin
            ack_w[id_q] = 1'b1;
        end
    end

    // Count every completed operation and every completed zero result.
    // Both counters stop at all-ones instead of wrapping.
    always_comb begin
        ops_count_d  = ops_count_q;
        zero_count_d = zero_count_q;
        if (valid_q && (ops_count_q != CNT_MAX)) begin
            ops_count_d = ops_count_q + 16'd1;
        end
        if (zero_now && (zero_count_q != CNT_MAX)) begin
            zero_count_d = zero_count_q + 16'd1;
        end
    end

    // Pipeline and pointer registers. Reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            op_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops_count_q  <= '0;
            zero_count_q <= '0;
        end else begin
            ops_count_q  <= ops_count_d;
            zero_count_q <= zero_count_d;
        end
    end

    assign bus.ack    = ack_w;
    assign bus.zero   = zero_now;
    assign bus.busy   = valid_q;
    assign ops_count  = ops_count_q;
    assign zero_count = zero_count_q;

    // At most one requester is acked per cycle.
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(ack_w));

    // zero can only be reported together with an ack.
    a_zero_needs_ack: assert property (@(posedge clk) disable iff (!reset)
        zero_now |-> (|ack_w));

    // A requester is never acked in two consecutive cycles.
    a_no_double_ack: assert property (@(posedge clk) disable iff (!reset)
        valid_q |=> !(valid_q && ($past(id_q) == id_q)));

    // A saturated counter stays saturated.
    a_ops_sat: assert property (@(posedge clk) disable iff (!reset)
        (ops_count_q == CNT_MAX) |=> (ops_count_q == CNT_MAX));

    a_zero_sat: assert property (@(posedge clk) disable iff (!reset)
        (zero_count_q == CNT_MAX) |=> (zero_count_q == CNT_MAX));

endmodule

// File: tb/tb_zero_check_arbiter.sv
// Bench for zero_check_arbiter: table vectors, directed corner-case
// sequences and a randomized phase against a cycle-level reference model.
module tb_zero_check_arbiter;

    localparam int WIDTH = 64;
    localparam int NREQ  = 4;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [15:0] ops_count;
    logic [15:0] zero_count;

    zero_check_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    zero_check_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ops_count  (ops_count),
        .zero_count (zero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // State of the result stage as seen in the current cycle.
    bit m_valid;
    int m_id;
    bit m_opzero;
    int m_ptr;
    int m_ops;
    int m_zeros;

    task automatic model_reset();
        m_valid  = 0;
        m_id     = 0;
        m_opzero = 0;
        m_ptr    = 0;
        m_ops    = 0;
        m_zeros  = 0;
    endtask

    // Compare the current cycle's outputs with the model, then advance the
    // model and the DUT by one clock. Called at a falling edge with the
    // inputs for this cycle already driven.
    task automatic cycle();
        logic [3:0] e_ack;
        int w;
        bit n_opzero;
        e_ack = m_valid ? 4'(1 << m_id) : 4'b0000;
        chk("ack",        64'(bus.ack),    64'(e_ack));
        chk("zero",       64'(bus.zero),   64'(m_valid && m_opzero));
        chk("busy",       64'(bus.busy),   64'(m_valid));
        chk("ops_count",  64'(ops_count),  64'(m_ops));
        chk("zero_count", 64'(zero_count), 64'(m_zeros));

        // Pick the first requesting index at or after the pointer, going round
        // the ring, excluding the requester whose result is being shown now.
        w = -1;
        if (bus.en) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req[c] && !(m_valid && m_id == c)) w = c;
            end
        end
        n_opzero = (w >= 0) ? (bus.data[w] == '0) : 1'b0;

        @(posedge clk);
        if (m_valid) begin
            if (m_ops < 65535) m_ops++;
            if (m_opzero && m_zeros < 65535) m_zeros++;
        end
        if (w >= 0) begin
            m_valid  = 1;
            m_id     = w;
            m_opzero = n_opzero;
            m_ptr    = (w + 1) % NREQ;
        end else begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    // Reset pulse. Entered and left at a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [3:0] r, input logic e, input logic [63:0] d);
        bus.req = r;
        bus.en  = e;
        for (int i = 0; i < NREQ; i++) bus.data[i] = d;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic [63:0] data;
        logic [3:0]  exp_ack;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] one64;

        vecs[0] = '{4'b0100, 1'b1, 64'h0,                   4'b0100, 1'b1};
        vecs[1] = '{4'b0001, 1'b1, 64'h8000_0000_0000_0000, 4'b0001, 1'b0};
        vecs[2] = '{4'b1000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
        vecs[3] = '{4'b0010, 1'b1, 64'h0,                   4'b0010, 1'b1};
        vecs[4] = '{4'b0001, 1'b1, 64'h1,                   4'b0001, 1'b0};
        vecs[5] = '{4'b0010, 1'b0, 64'h0,                   4'b0000, 1'b0};
        vecs[6] = '{4'b1000, 1'b1, 64'h0,                   4'b1000, 1'b1};

        reset = 1'b0;
        drive(4'b0000, 1'b0, 64'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset state, both during and just after reset.
        chk("rst_ack",   64'(bus.ack),  64'h0);
        chk("rst_zero",  64'(bus.zero), 64'h0);
        chk("rst_busy",  64'(bus.busy), 64'h0);
        chk("rst_ops",   64'(ops_count),  64'h0);
        chk("rst_zeros", 64'(zero_count), 64'h0);
        reset = 1'b1;
        cycle();

        // Single zero request: ack one cycle after the grant, counters at 1.
        drive(4'b0100, 1'b1, 64'h0);
        cycle();
        drive(4'b0000, 1'b1, 64'h0);
        chk("single_ack",  64'(bus.ack),  64'h4);
        chk("single_zero", 64'(bus.zero), 64'h1);
        cycle();
        chk("single_ops",   64'(ops_count),  64'h1);
        chk("single_zeros", 64'(zero_count), 64'h1);
        cycle();

        // Table: one grant cycle, then the result cycle with req dropped.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].req, vecs[v].en, vecs[v].data);
            cycle();
            drive(4'b0000, 1'b1, 64'h0);
            chk($sformatf("vec%0d_ack", v),  64'(bus.ack),  64'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_zero", v), 64'(bus.zero), 64'(vecs[v].exp_zero));
            cycle();
            cycle();
        end

        // Every single set bit makes the operand nonzero.
        one64 = 64'h1;
        for (int b = 0; b < WIDTH; b++) begin
            drive(4'b0001, 1'b1, one64 << b);
            cycle();
            drive(4'b0000, 1'b1, 64'h0);
            chk($sformatf("bit%0d_ack", b),  64'(bus.ack),  64'h1);
            chk($sformatf("bit%0d_zero", b), 64'(bus.zero), 64'h0);
            cycle();
        end

        // Round robin from reset with all four requesting continuously.
        do_reset();
        drive(4'b1111, 1'b1, 64'h5);
        cycle();
        for (int k = 0; k < 8; k++) begin
            logic [3:0] one4;
            one4 = 4'b0001;
            chk($sformatf("rr%0d_ack", k), 64'(bus.ack), 64'(one4 << (k % 4)));
            cycle();
        end

        // A lone continuous requester is served every other cycle.
        do_reset();
        drive(4'b0010, 1'b1, 64'h0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("alone%0d_busy", k), 64'(bus.busy), 64'(k % 2));
            chk($sformatf("alone%0d_ack", k),  64'(bus.ack),  (k % 2) ? 64'h2 : 64'h0);
            cycle();
        end
        drive(4'b0000, 1'b1, 64'h0);
        chk("alone_end_busy", 64'(bus.busy), 64'h0);
        cycle();

        // Reset in the middle of an operation aborts it; ptr restarts at 0.
        drive(4'b1111, 1'b1, 64'h0);
        cycle();
        cycle();
        chk("mid_busy_before", 64'(bus.busy), 64'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ack",   64'(bus.ack),    64'h0);
        chk("mid_rst_busy",  64'(bus.busy),   64'h0);
        chk("mid_rst_ops",   64'(ops_count),  64'h0);
        chk("mid_rst_zeros", 64'(zero_count), 64'h0);
        model_reset();
        @(negedge clk);
        drive(4'b1010, 1'b1, 64'h0);
        reset = 1'b1;
        cycle();
        chk("post_rst_ack", 64'(bus.ack), 64'h2);
        cycle();
        drive(4'b0000, 1'b1, 64'h0);
        cycle();
        cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bus.req = 4'($urandom_range(0, 15));
            bus.en  = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       bus.data[i] = '0;
                    1:       bus.data[i] = 64'h1 << $urandom_range(0, 63);
                    default: bus.data[i] = {$urandom, $urandom};
                endcase
            end
            cycle();
        end

        // Counter saturation: 65534 zero-result ops, then a few more.
        do_reset();
        drive(4'b1111, 1'b1, 64'h0);
        for (int n = 0; n < 65535; n++) cycle();
        chk("sat_ops_fffe",   64'(ops_count),  64'hFFFE);
        chk("sat_zeros_fffe", 64'(zero_count), 64'hFFFE);
        for (int n = 0; n < 3; n++) cycle();
        chk("sat_ops_ffff",   64'(ops_count),  64'hFFFF);
        chk("sat_zeros_ffff", 64'(zero_count), 64'hFFFF);

        // en low: the in-flight operation still acks, then nothing more.
        bus.en = 1'b0;
        chk("en_off_inflight", 64'(bus.busy), 64'h1);
        cycle();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("en_off%0d_ack", n), 64'(bus.ack), 64'h0);
            chk($sformatf("en_off%0d_ops", n), 64'(ops_count), 64'hFFFF);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
